// File: rtl/intr_pkg.sv
// Shared types and helpers for the interrupt sequencer: FSM states, cause codes,
// pending-bit layout and the fixed-priority pick.
package intr_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StEnter   = 2'd1,
        StService = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CauseNone = 2'b00,
        CauseExt1 = 2'b01,
        CauseExt2 = 2'b10,
        CauseTmr  = 2'b11
    } cause_e;

    localparam int unsigned PendW    = 3;
    localparam int unsigned PendExt1 = 0;
    localparam int unsigned PendExt2 = 1;
    localparam int unsigned PendTmr  = 2;

    localparam logic [1:0] LevelMax = 2'd2;

    // Fixed priority: ext1 > ext2 > timer.
    function automatic cause_e prio_pick(input logic [PendW-1:0] req);
        cause_e c;
        c = CauseNone;
        if (req[PendExt1]) begin
            c = CauseExt1;
        end else if (req[PendExt2]) begin
            c = CauseExt2;
        end else if (req[PendTmr]) begin
            c = CauseTmr;
        end
        return c;
    endfunction

    function automatic logic [PendW-1:0] cause_mask(input cause_e c);
        logic [PendW-1:0] m;
        m = '0;
        case (c)
            CauseExt1: m[PendExt1] = 1'b1;
            CauseExt2: m[PendExt2] = 1'b1;
            CauseTmr:  m[PendTmr]  = 1'b1;
            default:   m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/intr_ctrl_sync_edge.sv
// Two-flop synchroniser for an asynchronous level input followed by a
// rising-edge detector; rise_o is a one-cycle pulse in the clk_i domain.
module intr_ctrl_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt sequencer: latches ext1/ext2/timer requests, arbitrates by fixed
// priority, issues a one-cycle entry strobe and tracks handler nesting depth.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter bit NEST_EN = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       irq_ext1_i,
    input  logic       irq_ext2_i,
    input  logic       timer_tick_i,
    input  logic       ien_set_i,
    input  logic       ien_clr_i,
    input  logic       iret_i,
    output logic       take_intr_o,
    output logic       vec_sel_o,
    output logic [1:0] cause_o,
    output logic       in_service_o,
    output logic [1:0] level_o,
    output logic [2:0] pending_o,
    output logic       ien_o
);

    logic             rise_ext1;
    logic             rise_ext2;
    logic [PendW-1:0] set_vec;
    logic [PendW-1:0] clr_vec;
    logic [PendW-1:0] elig;
    logic [PendW-1:0] pend_q, pend_d;
    logic             ien_q, ien_d;
    logic [1:0]       level_q, level_d;
    state_e           state_q, state_d;
    cause_e           cause_q, cause_d;
    cause_e           shadow_q, shadow_d;
    cause_e           win;

    intr_ctrl_sync_edge u_sync_ext1 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (irq_ext1_i),
        .rise_o  (rise_ext1)
    );

    intr_ctrl_sync_edge u_sync_ext2 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (irq_ext2_i),
        .rise_o  (rise_ext2)
    );

    assign set_vec = {timer_tick_i, rise_ext2, rise_ext1};

    // Only ext1 may preempt, and only a single non-ext1 handler.
    always_comb begin
        elig = '0;
        unique case (state_q)
            StIdle: elig = pend_q & {PendW{ien_q}};
            StService: begin
                if (NEST_EN && (level_q == 2'd1) && (cause_q != CauseExt1)) begin
                    elig[PendExt1] = pend_q[PendExt1];
                end
            end
            default: elig = '0;
        endcase
    end

    assign win = prio_pick(elig);

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        shadow_d = shadow_q;
        level_d  = level_q;
        clr_vec  = '0;
        unique case (state_q)
            StIdle: begin
                if (win != CauseNone) begin
                    state_d = StEnter;
                    cause_d = win;
                    clr_vec = cause_mask(win);
                    level_d = (level_q == LevelMax) ? LevelMax : level_q + 2'd1;
                end
            end
            StEnter: state_d = StService;
            StService: begin
                // A return beats a simultaneous nesting request.
                if (iret_i) begin
                    if (level_q == LevelMax) begin
                        level_d = 2'd1;
                        cause_d = shadow_q;
                    end else begin
                        level_d = 2'd0;
                        state_d = StIdle;
                    end
                end else if (win != CauseNone) begin
                    state_d  = StEnter;
                    shadow_d = cause_q;
                    cause_d  = win;
                    clr_vec  = cause_mask(win);
                    level_d  = (level_q == LevelMax) ? LevelMax : level_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pend_d = (pend_q & ~clr_vec) | set_vec;

    always_comb begin
        ien_d = ien_q;
        if (ien_clr_i) begin
            ien_d = 1'b0;
        end else if (ien_set_i) begin
            ien_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cause_q  <= CauseNone;
            shadow_q <= CauseNone;
            level_q  <= 2'd0;
            pend_q   <= '0;
            ien_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            shadow_q <= shadow_d;
            level_q  <= level_d;
            pend_q   <= pend_d;
            ien_q    <= ien_d;
        end
    end

    assign take_intr_o  = (state_q == StEnter);
    assign vec_sel_o    = (cause_q == CauseExt2) || (cause_q == CauseTmr);
    assign cause_o      = cause_q;
    assign in_service_o = (level_q != 2'd0);
    assign level_o      = level_q;
    assign pending_o    = pend_q;
    assign ien_o        = ien_q;

endmodule
